stream_out_axis_master: RTL

Drains the BRAM output stream queue and presents its contents as an AXI4-Stream master toward the DMA S2MM channel. Issues single-cycle dequeue pulses, absorbs the queue's one-cycle BRAM read latency, and tolerates arbitrary `m_axis_tready` backpressure through a 3-entry output buffer. Data is framed into packets of a software-programmed beat count, and `m_axis_tlast` is asserted on the final beat of each packet.

---
 rtl/stream_out_pkg.sv | 22 ++
 rtl/stream_out_axis_master_if.sv | 23 ++
 rtl/stream_out_skid.sv | 65 ++++++
 rtl/stream_out_axis_master.sv | 120 ++++++++++++
 4 files changed

// File: rtl/stream_out_pkg.sv
// -----------------------------------------------------------------------------
// stream_out_pkg
// Shared definitions for the output-stream AXI4-Stream master:
//   - state_t      : FSM encodings (IDLE / RUN / FLUSH)
//   - SKID_DEPTH   : entries in the output buffer, which is also the pop credit
//   - QUEUE_RD_LAT : read latency of the BRAM queue, in cycles
//   - SKID_CW      : width of the buffer occupancy count
// -----------------------------------------------------------------------------
package stream_out_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int SKID_DEPTH   = 3;
   localparam int QUEUE_RD_LAT = 1;
   localparam int SKID_CW      = $clog2(SKID_DEPTH + 1);
   localparam int SKID_PW      = $clog2(SKID_DEPTH);

endpackage

// File: rtl/stream_out_axis_master_if.sv
// -----------------------------------------------------------------------------
// stream_out_axis_master_if
// AXI4-Stream bundle between the stream-out master and the DMA S2MM channel.
// Signals:
//   tdata  [DWIDTH-1:0]   beat data
//   tkeep  [DWIDTH/8-1:0] byte enables
//   tvalid                beat valid
//   tlast                 final beat of packet
//   tready                sink ready
// Modports: master (drives data side), slave (drives tready).
// -----------------------------------------------------------------------------
interface stream_out_axis_master_if #(
   parameter int DWIDTH = 128
);
   logic [DWIDTH-1:0]   tdata;
   logic [DWIDTH/8-1:0] tkeep;
   logic                tvalid;
   logic                tlast;
   logic                tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_out_skid.sv
// -----------------------------------------------------------------------------
// stream_out_skid
// Small register FIFO (SKID_DEPTH entries) that absorbs queue data while the
// stream sink applies backpressure. The caller never pushes when full and
// never pops when empty.
// Ports:
//   i_clk, i_rst   clock, synchronous active-low reset
//   push/push_data write one entry at the tail
//   pop            drop the head entry
//   head_data      current head entry
//   count          number of valid entries
// -----------------------------------------------------------------------------
module stream_out_skid
   import stream_out_pkg::*;
#(
   parameter int DWIDTH = 128
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               push,
   input  logic [DWIDTH-1:0]  push_data,
   input  logic               pop,
   output logic [DWIDTH-1:0]  head_data,
   output logic [SKID_CW-1:0] count
);

   logic [DWIDTH-1:0]    mem_reg [SKID_DEPTH];
   logic [SKID_PW-1:0]   wr_ptr_reg;
   logic [SKID_PW-1:0]   rd_ptr_reg;
   logic [SKID_CW-1:0]   count_reg;
   logic [SKID_DEPTH-1:0] wr_en;

   function automatic logic [SKID_PW-1:0] ptr_inc(input logic [SKID_PW-1:0] p);
      return (p == SKID_PW'(SKID_DEPTH - 1)) ? '0 : p + SKID_PW'(1);
   endfunction

   for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == SKID_PW'(gi));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem_reg[i] <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            if (wr_en[i]) mem_reg[i] <= push_data;
         end
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         // Simultaneous push and pop leaves occupancy unchanged.
         case ({push, pop})
            2'b10:   count_reg <= count_reg + SKID_CW'(1);
            2'b01:   count_reg <= count_reg - SKID_CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head_data = mem_reg[rd_ptr_reg];
   assign count     = count_reg;

endmodule

// File: rtl/stream_out_axis_master.sv
// -----------------------------------------------------------------------------
// stream_out_axis_master
// Drains the BRAM output queue into an AXI4-Stream master, framing packets of
// a programmed beat count with tlast on the final beat.
// Ports:
//   i_clk, i_rst        clock, synchronous active-low reset
//   i_start, i_len      request one packet of i_len beats (ignored if 0/busy)
//   o_busy, o_done      packet in progress / one-cycle completion pulse
//   i_q_empty           queue empty flag
//   o_q_dequeue         queue pop (data returns QUEUE_RD_LAT cycles later)
//   i_q_data            queue read data
//   m_axis              AXI4-Stream master bundle
// -----------------------------------------------------------------------------
module stream_out_axis_master
   import stream_out_pkg::*;
#(
   parameter int DWIDTH  = 128,
   parameter int LEN_BIT = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [LEN_BIT-1:0]  i_len,
   output logic                o_busy,
   output logic                o_done,
   input  logic                i_q_empty,
   output logic                o_q_dequeue,
   input  logic [DWIDTH-1:0]   i_q_data,
   stream_out_axis_master_if.master m_axis
);

   state_t                    state_reg;
   logic [LEN_BIT-1:0]        len_reg;
   logic [LEN_BIT-1:0]        issued_reg;
   logic [LEN_BIT-1:0]        sent_reg;
   logic [QUEUE_RD_LAT-1:0]   inflight_reg;
   logic                      busy_reg;
   logic                      done_reg;

   logic [SKID_CW-1:0]        buf_count;
   logic [DWIDTH-1:0]         head_data;
   logic [SKID_CW:0]          credits_used;
   logic                      q_dequeue;
   logic                      tvalid;
   logic                      tlast;
   logic                      beat_hs;
   logic                      last_hs;

   // A pop is only issued when the buffer is guaranteed a free slot for its
   // data, counting the pop whose read is still in flight.
   assign credits_used = {1'b0, buf_count} + (SKID_CW + 1)'(inflight_reg[QUEUE_RD_LAT-1]);
   assign q_dequeue    = (state_reg == ST_RUN) && !i_q_empty && (issued_reg < len_reg) &&
                         (credits_used < (SKID_CW + 1)'(SKID_DEPTH));

   assign tvalid  = (buf_count != '0);
   assign tlast   = tvalid && (sent_reg == len_reg - LEN_BIT'(1));
   assign beat_hs = tvalid && m_axis.tready;
   assign last_hs = beat_hs && tlast;

   stream_out_skid #(
      .DWIDTH (DWIDTH)
   ) u_skid (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .push      (inflight_reg[QUEUE_RD_LAT-1]),
      .push_data (i_q_data),
      .pop       (beat_hs),
      .head_data (head_data),
      .count     (buf_count)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_reg    <= ST_IDLE;
         len_reg      <= '0;
         issued_reg   <= '0;
         sent_reg     <= '0;
         inflight_reg <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         inflight_reg <= q_dequeue;
         done_reg     <= 1'b0;
         if (q_dequeue) issued_reg <= issued_reg + LEN_BIT'(1);
         if (beat_hs)   sent_reg   <= sent_reg + LEN_BIT'(1);
         case (state_reg)
            ST_IDLE: begin
               if (i_start && (i_len != '0)) begin
                  len_reg    <= i_len;
                  issued_reg <= '0;
                  sent_reg   <= '0;
                  busy_reg   <= 1'b1;
                  state_reg  <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Last pop issued: only draining remains.
               if (q_dequeue && (issued_reg + LEN_BIT'(1) == len_reg)) state_reg <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (last_hs) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign o_busy        = busy_reg;
   assign o_done        = done_reg;
   assign o_q_dequeue   = q_dequeue;
   assign m_axis.tdata  = head_data;
   assign m_axis.tkeep  = '1;
   assign m_axis.tvalid = tvalid;
   assign m_axis.tlast  = tlast;

endmodule
